// File: rtl/time_field_counter.sv
// Two-digit BCD up/down counter bounded to MIN_VAL..MAX_VAL with wrap pulses
// and a validated parallel load.
module time_field_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [3:0] new_tens,
  input  logic [3:0] new_ones,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       at_max,
  output logic       at_min,
  output logic       carry,
  output logic       borrow,
  output logic       set_err
);

  localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
  localparam logic [7:0] MIN_B = 8'(MIN_VAL);
  localparam logic [7:0] MAX_B = 8'(MAX_VAL);

  logic [7:0] load_val;
  logic       load_ok;

  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign at_min = (tens == MIN_T) && (ones == MIN_O);

  // Range check is only meaningful once both digits are known to be BCD.
  always_comb begin
    load_val = 8'(new_tens) * 8'd10 + 8'(new_ones);
    load_ok  = (new_tens <= 4'd9) && (new_ones <= 4'd9) &&
               (load_val >= MIN_B) && (load_val <= MAX_B);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens    <= MIN_T;
      ones    <= MIN_O;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      set_err <= 1'b0;
    end else begin
      carry   <= 1'b0;
      borrow  <= 1'b0;
      set_err <= 1'b0;
      if (set) begin
        if (load_ok) begin
          tens <= new_tens;
          ones <= new_ones;
        end else begin
          set_err <= 1'b1;
        end
      end else if (inc && !dec) begin
        if (at_max) begin
          tens  <= MIN_T;
          ones  <= MIN_O;
          carry <= 1'b1;
        end else if (ones == 4'd9) begin
          tens <= tens + 4'd1;
          ones <= 4'd0;
        end else begin
          ones <= ones + 4'd1;
        end
      end else if (dec && !inc) begin
        if (at_min) begin
          tens   <= MAX_T;
          ones   <= MAX_O;
          borrow <= 1'b1;
        end else if (ones == 4'd0) begin
          tens <= tens - 4'd1;
          ones <= 4'd9;
        end else begin
          ones <= ones - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_field_counter.sv
// Bench for time_field_counter: three instances (0..59, 1..12, 0..23) compared
// every cycle against an integer-valued reference model.
module tb_time_field_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       st  [3];
  logic [3:0] nt  [3];
  logic [3:0] no  [3];
  logic       inc [3];
  logic       dec [3];
  logic [3:0] tens [3];
  logic [3:0] ones [3];
  logic       at_max [3];
  logic       at_min [3];
  logic       carry  [3];
  logic       borrow [3];
  logic       set_err [3];

  int mins [3] = '{0, 1, 0};
  int maxs [3] = '{59, 12, 23};
  int m_val [3];
  bit m_c [3];
  bit m_b [3];
  bit m_e [3];

  int checks = 0;
  int errors = 0;

  time_field_counter #(.MIN_VAL(0), .MAX_VAL(59)) dut0 (
    .clk(clk), .reset(rst[0]), .set(st[0]), .new_tens(nt[0]), .new_ones(no[0]),
    .inc(inc[0]), .dec(dec[0]), .tens(tens[0]), .ones(ones[0]),
    .at_max(at_max[0]), .at_min(at_min[0]), .carry(carry[0]),
    .borrow(borrow[0]), .set_err(set_err[0]));

  time_field_counter #(.MIN_VAL(1), .MAX_VAL(12)) dut1 (
    .clk(clk), .reset(rst[1]), .set(st[1]), .new_tens(nt[1]), .new_ones(no[1]),
    .inc(inc[1]), .dec(dec[1]), .tens(tens[1]), .ones(ones[1]),
    .at_max(at_max[1]), .at_min(at_min[1]), .carry(carry[1]),
    .borrow(borrow[1]), .set_err(set_err[1]));

  time_field_counter #(.MIN_VAL(0), .MAX_VAL(23)) dut2 (
    .clk(clk), .reset(rst[2]), .set(st[2]), .new_tens(nt[2]), .new_ones(no[2]),
    .inc(inc[2]), .dec(dec[2]), .tens(tens[2]), .ones(ones[2]),
    .at_max(at_max[2]), .at_min(at_min[2]), .carry(carry[2]),
    .borrow(borrow[2]), .set_err(set_err[2]));

  task automatic chk(input string tag, input int d, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0d expected %0d", tag, d, obs, exp);
    end
  endtask

  // Reference: value as a plain integer, stepped by the priority rules.
  task automatic model_step(input int d);
    int lv;
    m_c[d] = 0; m_b[d] = 0; m_e[d] = 0;
    lv = int'(nt[d]) * 10 + int'(no[d]);
    if (rst[d]) m_val[d] = mins[d];
    else if (st[d]) begin
      if (nt[d] <= 9 && no[d] <= 9 && lv >= mins[d] && lv <= maxs[d]) m_val[d] = lv;
      else m_e[d] = 1;
    end else if (inc[d] && dec[d]) begin
    end else if (inc[d]) begin
      if (m_val[d] == maxs[d]) begin m_val[d] = mins[d]; m_c[d] = 1; end
      else m_val[d] = m_val[d] + 1;
    end else if (dec[d]) begin
      if (m_val[d] == mins[d]) begin m_val[d] = maxs[d]; m_b[d] = 1; end
      else m_val[d] = m_val[d] - 1;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 0; st[d] = 0; nt[d] = 0; no[d] = 0; inc[d] = 0; dec[d] = 0;
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("tens",    d, {4'd0, tens[d]},   8'(m_val[d] / 10));
      chk("ones",    d, {4'd0, ones[d]},   8'(m_val[d] % 10));
      chk("at_max",  d, {7'd0, at_max[d]}, {7'd0, m_val[d] == maxs[d]});
      chk("at_min",  d, {7'd0, at_min[d]}, {7'd0, m_val[d] == mins[d]});
      chk("carry",   d, {7'd0, carry[d]},  {7'd0, m_c[d]});
      chk("borrow",  d, {7'd0, borrow[d]}, {7'd0, m_b[d]});
      chk("set_err", d, {7'd0, set_err[d]}, {7'd0, m_e[d]});
    end
    clear_inputs();
  endtask

  task automatic do_set(input int d, input int t, input int o);
    st[d] = 1; nt[d] = 4'(t); no[d] = 4'(o);
  endtask

  int carries;

  initial begin
    clear_inputs();
    for (int d = 0; d < 3; d++) rst[d] = 1;
    tick();

    // 0..59: inc held 60 cycles, exactly one carry right after 59 -> 00
    carries = 0;
    for (int i = 0; i < 60; i++) begin
      inc[0] = 1;
      tick();
      if (carry[0]) carries++;
    end
    chk("wrap_carry_count", 0, 8'(carries), 8'd1);

    // 00 dec -> 59 with borrow
    dec[0] = 1; tick();
    chk("dec_wrap_at_max", 0, {7'd0, at_max[0]}, 8'd1);
    tick();

    // Rejected loads then a good one
    do_set(0, 6, 0); tick();
    do_set(0, 3, 10); tick();
    do_set(0, 4, 5); tick();

    // Both inc/dec, set beats inc, reset beats wrap
    do_set(0, 3, 9); tick();
    inc[0] = 1; dec[0] = 1; tick();
    do_set(0, 1, 2); inc[0] = 1; tick();
    do_set(0, 5, 9); tick();
    inc[0] = 1; rst[0] = 1; tick();
    inc[0] = 1; tick();

    // 1..12
    rst[1] = 1; tick();
    do_set(1, 1, 2); tick();
    inc[1] = 1; tick();
    dec[1] = 1; tick();
    do_set(1, 0, 0); tick();

    // 0..23 digit rollovers
    do_set(2, 0, 9); tick(); inc[2] = 1; tick();
    do_set(2, 1, 9); tick(); inc[2] = 1; tick();
    do_set(2, 2, 3); tick(); inc[2] = 1; tick();
    do_set(2, 1, 0); tick(); dec[2] = 1; tick();
    do_set(2, 2, 4); tick();

    // Randomized traffic on all three instances
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 3; d++) begin
        rst[d] = ($urandom_range(0, 63) == 0);
        st[d]  = ($urandom_range(0, 7) == 0);
        nt[d]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 9));
        no[d]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 9));
        inc[d] = ($urandom_range(0, 2) != 0);
        dec[d] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_field_counter.md
TIME_FIELD_COUNTER -- requirements
Module: time_field_counter

Interface
REQ-001 Parameter MIN_VAL, default 0: lowest count value (decimal); legal 0..98.
REQ-002 Parameter MAX_VAL, default 59: highest count value (decimal); legal MIN_VAL+1..99.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 set  input  1  load request for {new_tens,new_ones}.
REQ-006 new_tens  input  4  BCD tens digit of load value.
REQ-007 new_ones  input  4  BCD ones digit of load value.
REQ-008 inc  input  1  count up by one this cycle.
REQ-009 dec  input  1  count down by one this cycle.
REQ-010 tens  output  4  registered BCD tens digit of current value.
REQ-011 ones  output  4  registered BCD ones digit of current value.
REQ-012 at_max  output  1  combinational; high while value == MAX_VAL.
REQ-013 at_min  output  1  combinational; high while value == MIN_VAL.
REQ-014 carry  output  1  registered one-cycle pulse: wrapped MAX_VAL -> MIN_VAL on previous edge.
REQ-015 borrow  output  1  registered one-cycle pulse: wrapped MIN_VAL -> MAX_VAL on previous edge.
REQ-016 set_err  output  1  registered one-cycle pulse: previous-cycle load was rejected.

Function
REQ-017 Value SHALL be held as two BCD digits; tens and ones SHALL never leave 0..9.
REQ-018 Per-edge priority SHALL be: reset > set > (inc and dec both high) > inc > dec > hold.
REQ-019 set SHALL be accepted only when new_tens <= 9, new_ones <= 9, and MIN_VAL <= 10*new_tens+new_ones <= MAX_VAL; accepted load takes effect next edge.
REQ-020 Rejected set SHALL leave value unchanged, assert set_err for one cycle, and still suppress inc/dec that cycle.
REQ-021 inc alone: value < MAX_VAL -> value+1 with BCD ones-to-tens rollover (x9 -> (x+1)0); value == MAX_VAL -> MIN_VAL and carry=1 next cycle.
REQ-022 dec alone: value > MIN_VAL -> value-1 with BCD borrow ((x)0 -> (x-1)9); value == MIN_VAL -> MAX_VAL and borrow=1 next cycle.
REQ-023 inc and dec both high (no set): value held, no carry/borrow pulse.
REQ-024 carry, borrow, set_err SHALL be low in every cycle not caused by their event; held-high inc at MAX_VAL SHALL produce exactly one carry per wrap.
REQ-025 Latency: value change visible on tens/ones one cycle after the qualifying edge; at_max/at_min follow tens/ones with zero added latency.
REQ-026 Block SHALL support one update per clock with inc held continuously (no idle cycles required).

Reset
REQ-027 reset high at an edge SHALL force value = MIN_VAL (tens = MIN_VAL/10, ones = MIN_VAL%10) and carry = borrow = set_err = 0, overriding set/inc/dec.
REQ-028 reset asserted mid-operation (e.g. coincident with a wrap) SHALL suppress that cycle's carry/borrow pulse.
REQ-029 After reset deasserts, first inc/dec/set SHALL be honoured on the first subsequent edge.

Verification
REQ-030 Defaults (0..59): reset, then inc held 60 cycles -> values 01..59 then 00; carry high exactly once, cycle after 59->00.
REQ-031 Defaults: value 00, dec one cycle -> value 59, borrow=1 for one cycle, at_max=1.
REQ-032 MIN_VAL=1, MAX_VAL=12: reset -> 01; set 12 then inc -> 01 with carry; dec at 01 -> 12 with borrow.
REQ-033 Defaults: set with {6,0}, then {3,10} -> value unchanged, set_err pulse each; set {4,5} -> 45, no set_err.
REQ-034 Defaults: value 39, inc and dec both high -> 39 held; value 39, set {1,2} with inc high -> 12 (set wins); value 59, inc with reset -> 00, carry=0.
REQ-035 MIN_VAL=0, MAX_VAL=23: inc from 09 -> 10, from 19 -> 20, from 23 -> 00 with carry; dec from 10 -> 09.
